// File: rtl/tophat_pkg.sv
// Shared types and constants for the tophat host-link UART blocks.
package tophat_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/tophat_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; shared by the UART tx and rx paths.
module tophat_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Push is refused when full even if a pop happens in the same cycle (no bypass).
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/tophat_uart_tx.sv
// UART 8N1 transmitter: valid/ready byte port into a small FIFO feeding a serializer.
module tophat_uart_tx
  import tophat_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_e  state_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       tx_q;

  logic       full, empty, push, pop, baud_last;
  logic [7:0] head;

  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign baud_last = (baud_q == BAUD_LAST);
  // ena is only consulted where a new frame could begin: idle, or the last stop-bit cycle.
  assign pop = ena & ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_last));

  tophat_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            shift_q <= head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              shift_q <= head;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_tophat_uart_tx.sv
// Self-checking bench for tophat_uart_tx: directed scenarios plus random traffic
// checked by a line decoder that rebuilds bytes from the tx waveform.
module tb_tophat_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         rx_bad = 0;

  tophat_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level during bit slot k of a frame carrying byte b.
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Line decoder: a frame is 40 samples from the falling edge; every bit slot must be flat.
  initial begin
    bit         inf;
    int         n;
    int         start_c;
    bit         ok;
    logic [39:0] s;
    logic [7:0] d;
    inf = 0; n = 0; start_c = 0; s = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inf = 0;
        n = 0;
      end else if (!inf) begin
        if (tx === 1'b0) begin
          inf = 1; s = '0; n = 1; start_c = cyc;
        end
      end else begin
        s[n] = tx;
        n++;
        if (n == FRAME) begin
          ok = 1;
          d = '0;
          for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CPB; j++) if (s[k*CPB+j] !== s[k*CPB]) ok = 0;
            if (s[k*CPB] !== line_bit(8'h00, k) && (k == 0 || k == 9)) ok = 0;
            if (k >= 1 && k <= 8) d[k-1] = s[k*CPB];
          end
          if (!ok) rx_bad++;
          rx_q.push_back(d);
          rx_start_q.push_back(start_c);
          inf = 0;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int  k;
    bit  rdy;
    in_data = b;
    in_valid = 1'b1;
    k = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 2000);
    in_valid = 1'b0;
    ok = rdy;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit timed_out);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    timed_out = (rx_q.size() < n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    rx_q.delete();
    rx_start_q.delete();
    rx_bad = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit ok;
    logic e;
    wait_idle();
    ena = 1'b1;
    push_byte(8'hA5, ok);
    checks++; if (!ok || tx !== 1'b1) begin errors++; $display("FAIL single_latency: accepted %b tx %b want 1 1", ok, tx); end
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge clk); #1;
      e = line_bit(8'hA5, (j - 1) / CPB);
      checks++; if (tx !== e) begin errors++; $display("FAIL single_line cyc%0d: got %b want %b", j, tx, e); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy40: got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy41: got %b want 0", busy); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || rx_bad != 0) begin
      errors++; $display("FAIL single_decode: n=%0d byte=%h bad=%0d want 1 a5 0", rx_q.size(), rx_q[0], rx_bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, to;
    wait_idle();
    ena = 1'b1;
    push_byte(8'h00, ok1);
    push_byte(8'hFF, ok2);
    wait_frames(2, 300, to);
    checks++; if (to || !ok1 || !ok2) begin errors++; $display("FAIL b2b_timeout: frames %0d want 2", rx_q.size()); end
    checks++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_order: got %h %h want 00 ff", rx_q[0], rx_q[1]);
    end
    checks++; if (rx_start_q[1] - rx_start_q[0] != FRAME || rx_bad != 0) begin
      errors++; $display("FAIL b2b_spacing: got %0d bad %0d want %0d 0", rx_start_q[1] - rx_start_q[0], rx_bad, FRAME);
    end
  endtask

  task automatic test_ena_hold();
    logic [7:0] d[5];
    bit ok, to;
    wait_idle();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) push_byte(d[i], ok);
    in_data = d[4];
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL hold_level: got %0d want 4", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", in_ready); end
    checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL hold_line: tx %b busy %b want 1 1", tx, busy); end
    ena = 1'b1;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 3'd3 || in_ready !== 1'b1 || tx !== 1'b0) begin
      errors++; $display("FAIL hold_pop: level %0d ready %b tx %b want 3 1 0", fifo_level, in_ready, tx);
    end
    @(posedge clk); #1;
    checks++; if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_fifth: level %0d ready %b want 4 0", fifo_level, in_ready);
    end
    in_valid = 1'b0;
    wait_frames(5, 400, to);
    checks++; if (to) begin errors++; $display("FAIL hold_timeout: frames %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx_q[i] !== d[i]) begin errors++; $display("FAIL hold_byte%0d: got %h want %h", i, rx_q[i], d[i]); end
    end
  endtask

  task automatic test_ena_drop();
    logic [7:0] d[3];
    bit ok, to;
    wait_idle();
    ena = 1'b1;
    for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) push_byte(d[i], ok);
    repeat (11) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 1 || rx_q[0] !== d[0] || rx_bad != 0) begin
      errors++; $display("FAIL drop_frame: n=%0d byte=%h bad=%0d want 1 %h 0", rx_q.size(), rx_q[0], rx_bad, d[0]);
    end
    checks++; if (tx !== 1'b1 || fifo_level !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL drop_retain: tx %b level %0d busy %b want 1 2 1", tx, fifo_level, busy);
    end
    ena = 1'b1;
    wait_frames(3, 300, to);
    checks++; if (to || rx_q[1] !== d[1] || rx_q[2] !== d[2]) begin
      errors++; $display("FAIL drop_resume: got %h %h want %h %h", rx_q[1], rx_q[2], d[1], d[2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    wait_idle();
    ena = 1'b1;
    push_byte(8'h00, ok);
    push_byte(8'h3C, ok);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre: tx %b want 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_async_tx: got %b want 1", tx); end
    checks++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_state: level %0d busy %b want 0 0", fifo_level, busy);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 0 || tx !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_after: frames %0d tx %b level %0d busy %b want 0 1 0 0", rx_q.size(), tx, fifo_level, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit ok, to, all_ok;
    wait_idle();
    all_ok = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3) * $urandom_range(0, 1) * 20) begin
        ena = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      ena = 1'b1;
      b = 8'($urandom);
      push_byte(b, ok);
      if (!ok) all_ok = 0;
      exp_q.push_back(b);
    end
    ena = 1'b1;
    wait_frames(200, 1000, to);
    checks++; if (to || !all_ok) begin errors++; $display("FAIL rand_timeout: frames %0d want 200", rx_q.size()); end
    checks++; if (rx_q.size() != 200 || rx_bad != 0) begin
      errors++; $display("FAIL rand_count: frames %0d bad %0d want 200 0", rx_q.size(), rx_bad);
    end
    for (int i = 0; i < 200; i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rx_start_q.size(); i++) begin
      checks++; if (rx_start_q[i] - rx_start_q[i-1] < FRAME) begin
        errors++; $display("FAIL rand_spacing%0d: got %0d want >= %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ena_hold();
    test_ena_drop();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
